// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - command, register-load, ALU and status bundle for alu_seq_ctrl
// master: command source / ALU / debug side; slave: the sequencer.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [AW-1:0]     cmd_ra;
  logic [AW-1:0]     cmd_rb;
  logic [AW-1:0]     cmd_rd;

  logic              ld_en;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_z;
  logic              alu_c;

  logic              done;
  logic              z_flag;
  logic              c_flag;

  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    input  cmd_ready,
    output ld_en, ld_addr, ld_data,
    input  alu_op, alu_a, alu_b,
    output alu_y, alu_z, alu_c,
    input  done, z_flag, c_flag,
    output dbg_addr,
    input  dbg_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    output cmd_ready,
    input  ld_en, ld_addr, ld_data,
    output alu_op, alu_a, alu_b,
    input  alu_y, alu_z, alu_c,
    output done, z_flag, c_flag,
    input  dbg_addr,
    output dbg_data
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - four-state register-file sequencer driving an external 16-bit ALU
// Optional debug read port enabled by defining ALU_SEQ_DBG_EN.
module alu_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(REG_CNT);

  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [AW-1:0]     ra_q;
  logic [AW-1:0]     rb_q;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [2:0]        alu_op_q;
  logic [DATA_W-1:0] res_y_q;
  logic              res_z_q;
  logic              res_c_q;
  logic              z_q;
  logic              c_q;
  logic              done_q;
  logic [DATA_W-1:0] regs_q [REG_CNT];

  logic              ready_d;
  logic              accept_d;
  logic              carry_upd_d;

  assign ready_d     = (state_q == S_IDLE) && !reset;
  assign accept_d    = bus.cmd_valid && ready_d;
  // Shift and rotate leave the ALU carry undefined, so the old flag is kept.
  assign carry_upd_d = (op_q != OP_SHL) && (op_q != OP_ROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      alu_op_q <= '0;
      res_y_q  <= '0;
      res_z_q  <= 1'b0;
      res_c_q  <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (bus.ld_en) begin
        regs_q[bus.ld_addr] <= bus.ld_data;
      end
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            op_q    <= bus.cmd_op;
            ra_q    <= bus.cmd_ra;
            rb_q    <= bus.cmd_rb;
            rd_q    <= bus.cmd_rd;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          opa_q    <= regs_q[ra_q];
          opb_q    <= regs_q[rb_q];
          alu_op_q <= op_q;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          res_y_q <= bus.alu_y;
          res_z_q <= bus.alu_z;
          res_c_q <= bus.alu_c;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          // Placed after the load port so write-back wins an address collision.
          regs_q[rd_q] <= res_y_q;
          z_q          <= res_z_q;
          if (carry_upd_d) begin
            c_q <= res_c_q;
          end
          done_q   <= 1'b1;
          opa_q    <= '0;
          opb_q    <= '0;
          alu_op_q <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ready_d;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = opa_q;
  assign bus.alu_b     = opb_q;
  assign bus.done      = done_q;
  assign bus.z_flag    = z_q;
  assign bus.c_flag    = c_q;

`ifdef ALU_SEQ_DBG_EN
  assign bus.dbg_data = regs_q[bus.dbg_addr];
`else
  logic [AW-1:0] unused_dbg_addr;
  assign unused_dbg_addr = bus.dbg_addr;
  assign bus.dbg_data    = '0;
`endif
endmodule
